window_collector_kxk: RTL and testbench

- Parametrised successor to the 3x3 line-buffer window collector.
- Converts a raster pixel stream into KxK sliding windows for the conv engine.
- Adds: configurable data width and kernel size, valid-qualified input, runtime image width and height, frame start, stride-1/2 mode, and window validity and coordinate outputs.
- Sits between the activation stream source and the MAC array.

---
 rtl/window_collector_kxk.sv | 167 ++++++++++++++++
 tb/tb_window_collector_kxk.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/window_collector_kxk.sv
// KxK sliding-window collector: turns a raster pixel stream into windows using K-1 line buffers
// and a KxK shift register, with runtime frame size, stride-2 decimation and coordinate tags.
module window_collector_kxk #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned K         = 3,
  parameter int unsigned MAX_WIDTH = 128,
  parameter int unsigned DIM_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     pixel_in,
  input  logic                  sof,
  input  logic [DIM_BITS-1:0]   stage_width,
  input  logic [DIM_BITS-1:0]   stage_height,
  input  logic                  stride2,
  output logic                  win_valid,
  output logic [K*K*DATA_W-1:0] win_out,
  output logic [DIM_BITS-1:0]   win_row,
  output logic [DIM_BITS-1:0]   win_col,
  output logic                  frame_done,
  output logic                  cfg_err
);

  localparam int unsigned AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int unsigned NB = K - 1;

  // Frame configuration, captured on an accepted sof pixel.
  logic [DIM_BITS-1:0] width_q, height_q;
  logic                stride2_q;

  // Coordinate expected for the next accepted pixel.
  logic [DIM_BITS-1:0] row_q, col_q;

  logic [DIM_BITS-1:0] cur_w, cur_h, cur_row, cur_col;
  logic                cur_s2, cur_err, legal_new;
  logic                last_col, last_row;
  logic [DIM_BITS-1:0] row_d, col_d;
  logic [DIM_BITS-1:0] wr, wc;
  logic                row_ok, col_ok, phase_ok, win_valid_d;

  logic [AW-1:0]       addr;
  logic [DATA_W-1:0]   lb_mem [NB][MAX_WIDTH];
  logic [DATA_W-1:0]   lb_rd  [NB];
  logic [DATA_W-1:0]   col_new [K];

  logic [K*K-1:0][DATA_W-1:0] win_q, win_d;

  // A sof pixel uses the incoming config and is forced to (0,0).
  always_comb begin
    legal_new = (32'(stage_width) >= K) && (32'(stage_width) <= MAX_WIDTH) &&
                (32'(stage_height) >= K);
    if (sof) begin
      cur_w   = stage_width;
      cur_h   = stage_height;
      cur_s2  = stride2;
      cur_err = !legal_new;
      cur_row = '0;
      cur_col = '0;
    end else begin
      cur_w   = width_q;
      cur_h   = height_q;
      cur_s2  = stride2_q;
      cur_err = cfg_err;
      cur_row = row_q;
      cur_col = col_q;
    end
  end

  always_comb begin
    last_col = (cur_col == cur_w - DIM_BITS'(1));
    last_row = (cur_row == cur_h - DIM_BITS'(1));
    row_d    = cur_row;
    col_d    = cur_col + DIM_BITS'(1);
    if (last_col) begin
      col_d = '0;
      row_d = last_row ? '0 : cur_row + DIM_BITS'(1);
    end
  end

  always_comb begin
    row_ok      = 32'(cur_row) >= (K - 1);
    col_ok      = 32'(cur_col) >= (K - 1);
    wr          = cur_row - DIM_BITS'(K - 1);
    wc          = cur_col - DIM_BITS'(K - 1);
    phase_ok    = !cur_s2 || (!wr[0] && !wc[0]);
    win_valid_d = in_valid && row_ok && col_ok && !cur_err && phase_ok;
  end

  // Line buffer j holds row r-1-j at each column; reads are combinational.
  assign addr = AW'(cur_col);

  always_comb begin
    for (int j = 0; j < NB; j++) begin
      lb_rd[j] = lb_mem[j][addr];
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb_mem[0][addr] <= pixel_in;
      for (int j = 1; j < NB; j++) begin
        lb_mem[j][addr] <= lb_rd[j-1];
      end
    end
  end

  // New right column, top (oldest row) to bottom (current pixel).
  always_comb begin
    for (int rr = 0; rr < K; rr++) begin
      col_new[rr] = (rr == K - 1) ? pixel_in : lb_rd[K-2-rr];
    end
  end

  always_comb begin
    win_d = win_q;
    for (int rr = 0; rr < K; rr++) begin
      for (int cc = 0; cc < K; cc++) begin
        if (cc < K - 1) begin
          win_d[rr*K+cc] = win_q[rr*K+cc+1];
        end else begin
          win_d[rr*K+cc] = col_new[rr];
        end
      end
    end
  end

  // Config survives reset so a stream can resume at (0,0) without a new sof.
  always_ff @(posedge clk) begin
    if (in_valid && sof) begin
      width_q   <= stage_width;
      height_q  <= stage_height;
      stride2_q <= stride2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= '0;
      col_q      <= '0;
      win_q      <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        row_q      <= row_d;
        col_q      <= col_d;
        win_q      <= win_d;
        win_valid  <= win_valid_d;
        win_row    <= wr;
        win_col    <= wc;
        frame_done <= last_col && last_row;
        if (sof) begin
          cfg_err <= !legal_new;
        end
      end
    end
  end

  assign win_out = win_q;

endmodule

// File: tb/tb_window_collector_kxk.sv
// Scoreboard bench for window_collector_kxk (K=3): stimulus pushes expected windows, a negedge
// monitor pops and compares them whenever win_valid is high.
module tb_window_collector_kxk;

  localparam int DW = 8;
  localparam int KK = 3;
  localparam int DB = 8;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [DW-1:0]   pixel_in;
  logic            sof;
  logic [DB-1:0]   stage_width;
  logic [DB-1:0]   stage_height;
  logic            stride2;
  logic            win_valid;
  logic [KK*KK*DW-1:0] win_out;
  logic [DB-1:0]   win_row;
  logic [DB-1:0]   win_col;
  logic            frame_done;
  logic            cfg_err;

  window_collector_kxk #(
    .DATA_W   (DW),
    .K        (KK),
    .MAX_WIDTH(128),
    .DIM_BITS (DB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .pixel_in    (pixel_in),
    .sof         (sof),
    .stage_width (stage_width),
    .stage_height(stage_height),
    .stride2     (stride2),
    .win_valid   (win_valid),
    .win_out     (win_out),
    .win_row     (win_row),
    .win_col     (win_col),
    .frame_done  (frame_done),
    .cfg_err     (cfg_err)
  );

  typedef struct packed {
    logic [7:0]  row;
    logic [7:0]  col;
    logic [71:0] win;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   win_cnt = 0;
  int   done_seen = 0;
  int   exp_done = 0;
  logic acc_q = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int base, input int r, input int c);
    return 8'(base + r * 16 + c);
  endfunction

  function automatic logic [71:0] mk_win(input int base, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int e = 0; e < 9; e++) begin
      w[e*8 +: 8] = pix(base, r + e / 3, c + e % 3);
    end
    return w;
  endfunction

  // Was a pixel accepted at the most recent rising edge?
  initial forever begin
    @(posedge clk);
    acc_q = in_valid && !rst;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (frame_done) done_seen++;
    if (win_valid) begin
      win_cnt++;
      chk("win_after_accept", 128'(acc_q), 128'(1));
      chk("win_cfg_err", 128'(cfg_err), 128'(0));
      if (sb_q.size() == 0) begin
        chk("unexpected_window", 128'({win_row, win_col}), 128'(16'hffff));
      end else begin
        e = sb_q.pop_front();
        chk("win_row", 128'(win_row), 128'(e.row));
        chk("win_col", 128'(win_col), 128'(e.col));
        chk("win_out", 128'(win_out), 128'(e.win));
        chk("frame_done_with_win", 128'(frame_done), 128'(e.last));
      end
    end
  end

  task automatic idle_cycle();
    in_valid = 1'b0;
    pixel_in = 8'($urandom);
    sof      = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int w, input int h, input int s2, input int base,
                            input int npix, input bit gaps, input bit use_sof);
    bit legal;
    int r, c;
    exp_t e;
    legal = (w >= 3) && (w <= 128) && (h >= 3);
    for (int p = 0; p < npix; p++) begin
      r = p / w;
      c = p % w;
      if (gaps) repeat ($urandom_range(0, 1)) idle_cycle();
      in_valid = 1'b1;
      pixel_in = pix(base, r, c);
      sof      = use_sof && (p == 0);
      // Config is only meaningful with sof; garbage elsewhere must be ignored.
      stage_width  = sof ? 8'(w) : 8'($urandom);
      stage_height = sof ? 8'(h) : 8'($urandom);
      stride2      = sof ? 1'(s2) : 1'($urandom);
      if (legal && r >= 2 && c >= 2 &&
          (s2 == 0 || (((r - 2) % 2) == 0 && ((c - 2) % 2) == 0))) begin
        e.row  = 8'(r - 2);
        e.col  = 8'(c - 2);
        e.win  = mk_win(base, r - 2, c - 2);
        e.last = (r == h - 1) && (c == w - 1);
        sb_q.push_back(e);
      end
      if (r == h - 1 && c == w - 1) exp_done++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    sof      = 1'b0;
  endtask

  task automatic drain_check(input string name, input int w0, input int want_wins);
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_sb_empty"}, 128'(sb_q.size()), 128'(0));
    chk({name, "_win_count"}, 128'(win_cnt - w0), 128'(want_wins));
    chk({name, "_done_count"}, 128'(done_seen), 128'(exp_done));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0;
    rst = 1'b1; in_valid = 1'b0; pixel_in = '0; sof = 1'b0;
    stage_width = '0; stage_height = '0; stride2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_win_valid", 128'(win_valid), 128'(0));
    chk("rst_win_out", 128'(win_out), 128'(0));
    chk("rst_win_row", 128'(win_row), 128'(0));
    chk("rst_win_col", 128'(win_col), 128'(0));
    chk("rst_frame_done", 128'(frame_done), 128'(0));
    chk("rst_cfg_err", 128'(cfg_err), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Continuous 5x4 stride-1 frame.
    w0 = win_cnt;
    send_frame(5, 4, 0, 8'h00, 20, 1'b0, 1'b1);
    drain_check("s1", w0, 6);

    // Same frame with random idle gaps.
    w0 = win_cnt;
    send_frame(5, 4, 0, 8'h00, 20, 1'b1, 1'b1);
    drain_check("s2", w0, 6);

    // 6x6 stride 2.
    w0 = win_cnt;
    send_frame(6, 6, 1, 8'h00, 36, 1'b0, 1'b1);
    drain_check("s3", w0, 4);

    // Frame aborted by sof at pixel 9, then a full frame with different data.
    w0 = win_cnt;
    d0 = done_seen;
    send_frame(5, 4, 0, 8'h80, 9, 1'b0, 1'b1);
    send_frame(5, 4, 0, 8'h00, 20, 1'b0, 1'b1);
    drain_check("s4", w0, 6);
    chk("s4_done_delta", 128'(done_seen - d0), 128'(1));

    // Illegal width, then a legal frame.
    w0 = win_cnt;
    send_frame(2, 4, 0, 8'h00, 8, 1'b0, 1'b1);
    drain_check("s5a", w0, 0);
    chk("s5a_cfg_err", 128'(cfg_err), 128'(1));
    w0 = win_cnt;
    send_frame(5, 4, 0, 8'h40, 20, 1'b0, 1'b1);
    drain_check("s5b", w0, 6);
    chk("s5b_cfg_err", 128'(cfg_err), 128'(0));

    // Reset mid-frame, then resume at (0,0) without sof.
    w0 = win_cnt;
    send_frame(5, 4, 0, 8'h00, 13, 1'b0, 1'b1);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_win_valid", 128'(win_valid), 128'(0));
    chk("mid_rst_win_out", 128'(win_out), 128'(0));
    chk("mid_rst_win_row", 128'(win_row), 128'(0));
    chk("mid_rst_win_col", 128'(win_col), 128'(0));
    chk("mid_rst_frame_done", 128'(frame_done), 128'(0));
    chk("mid_rst_cfg_err", 128'(cfg_err), 128'(0));
    rst = 1'b0;
    send_frame(5, 4, 0, 8'h00, 20, 1'b0, 1'b0);
    drain_check("s6", w0, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
